// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters share one fixed-latency memory port.
// Each access runs STROBE (1 cycle), WAIT (WAIT_CYCLES cycles) and DONE (1 cycle).
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties go to the port that was
// not granted last. When it is undefined (default), ties always go to port 0.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Req0Strobe,
    input  logic          Req0RW,
    input  logic [AW-1:0] Req0Addr,
    input  logic [DW-1:0] Req0WData,
    output logic          Req0Done,
    output logic [DW-1:0] Req0RData,
    input  logic          Req1Strobe,
    input  logic          Req1RW,
    input  logic [AW-1:0] Req1Addr,
    input  logic [DW-1:0] Req1WData,
    output logic          Req1Done,
    output logic [DW-1:0] Req1RData,
    output logic          MStrobe,
    output logic          MRW,
    output logic [AW-1:0] MAddr,
    output logic [DW-1:0] MWData,
    input  logic [DW-1:0] MRData,
    output logic          Busy,
    output logic          Grant
);

    typedef enum logic [1:0] {StIdle, StStrobe, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          any_req;
    logic          winner;
`ifdef ARB_ROUND_ROBIN_EN
    logic          ptr_q, ptr_d;
`endif

    // Pick the port that wins if a grant happens this cycle
    always_comb begin
        any_req = Req0Strobe | Req1Strobe;
`ifdef ARB_ROUND_ROBIN_EN
        if (Req0Strobe && Req1Strobe) begin
            winner = ~ptr_q;
        end else begin
            winner = ~Req0Strobe;
        end
`else
        // Port 0 has fixed priority; port 1 only wins when port 0 is not asking
        winner = ~Req0Strobe;
`endif
    end

    // Next-state logic for the access sequencer and its captured request
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt_d    = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StStrobe;
                    grant_d = winner;
                    rw_d    = winner ? Req1RW    : Req0RW;
                    addr_d  = winner ? Req1Addr  : Req0Addr;
                    wdata_d = winner ? Req1WData : Req0WData;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = winner;
`endif
                end
            end
            StStrobe: begin
                cnt_d   = 8'(WAIT_CYCLES);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StDone;
                    // Memory data is valid on the last wait cycle only
                    if (!rw_q) begin
                        if (grant_q) begin
                            rdata1_d = MRData;
                        end else begin
                            rdata0_d = MRData;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q    <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Outputs decode directly from registered state
    always_comb begin
        MStrobe   = (state_q == StStrobe);
        Busy      = (state_q != StIdle);
        Req0Done  = (state_q == StDone) && !grant_q;
        Req1Done  = (state_q == StDone) && grant_q;
        Grant     = grant_q;
        MRW       = rw_q;
        MAddr     = addr_q;
        MWData    = wdata_q;
        Req0RData = rdata0_q;
        Req1RData = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter. Follows ARB_ROUND_ROBIN_EN if it is defined.
module tb_mem_arbiter;
    localparam int W  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s [2];
    logic          rw [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd [2];
    logic          d [2];
    logic [DW-1:0] rd [2];
    logic          m_strobe, m_rw, busy, grant;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt [2] = '{0, 0};
    int seen [2] = '{0, 0};
    bit mon_en = 1'b0;
    logic [DW-1:0] mem [16];

    typedef struct {
        int            port;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        int            strobe_cyc;
        int            done_cyc;
    } exp_t;
    exp_t q[$];

    mem_arbiter #(.WAIT_CYCLES(W), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .Req0Strobe(s[0]), .Req0RW(rw[0]), .Req0Addr(addr[0]), .Req0WData(wd[0]),
        .Req0Done(d[0]), .Req0RData(rd[0]),
        .Req1Strobe(s[1]), .Req1RW(rw[1]), .Req1Addr(addr[1]), .Req1WData(wd[1]),
        .Req1Done(d[1]), .Req1RData(rd[1]),
        .MStrobe(m_strobe), .MRW(m_rw), .MAddr(m_addr), .MWData(m_wdata), .MRData(m_rdata),
        .Busy(busy), .Grant(grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grants from the arbitration rules, timing from fixed latencies
    int  free_cyc = 0;
    int  last = 0;
    logic [DW-1:0] exp_rd [2] = '{32'd0, 32'd0};
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            exp_rd   = '{32'd0, 32'd0};
            last     = 0;
            free_cyc = cyc + 1;
        end else if (cyc >= free_cyc && (s[0] || s[1])) begin
            exp_t e;
            int w;
            if (s[0] && s[1]) w = RrEn ? 1 - last : 0;
            else              w = s[0] ? 0 : 1;
            e.port  = w;
            e.rw    = rw[w];
            e.addr  = addr[w];
            e.wdata = wd[w];
            if (rw[w]) mem[addr[w][3:0]] = wd[w];
            else       exp_rd[w] = mem[addr[w][3:0]];
            e.rd0        = exp_rd[0];
            e.rd1        = exp_rd[1];
            e.strobe_cyc = cyc + 1;
            e.done_cyc   = cyc + W + 2;
            last         = w;
            free_cyc     = cyc + W + 3;
            q.push_back(e);
        end
    end

    // Memory device: read data valid only on the last wait cycle, junk otherwise
    int  dev_cnt = 0;
    bit  dev_act = 1'b0;
    always begin
        @(posedge clk);
        #1;
        m_rdata = $urandom;
        if (reset) begin
            dev_act = 1'b0;
        end else if (m_strobe) begin
            dev_act = 1'b1;
            dev_cnt = 0;
        end else if (dev_act) begin
            dev_cnt++;
            if (dev_cnt == W) begin
                m_rdata = mem[m_addr[3:0]];
                dev_act = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the front of the expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (d[0]) done_cnt[0] <= done_cnt[0] + 1;
            if (d[1]) done_cnt[1] <= done_cnt[1] + 1;
        end
        if (mon_en && !reset) begin
            if (q.size() > 0 && cyc >= q[0].strobe_cyc && cyc <= q[0].done_cyc) begin
                chk("busy", 64'(busy), 64'(1));
                chk("mstrobe", 64'(m_strobe), 64'(cyc == q[0].strobe_cyc));
                chk("grant", 64'(grant), 64'(q[0].port));
                chk("mrw", 64'(m_rw), 64'(q[0].rw));
                chk("maddr", 64'(m_addr), 64'(q[0].addr));
                if (q[0].rw) chk("mwdata", 64'(m_wdata), 64'(q[0].wdata));
            end else begin
                chk("busy_idle", 64'(busy), 64'(0));
                chk("mstrobe_idle", 64'(m_strobe), 64'(0));
            end
            if (d[0] || d[1]) begin
                if (q.size() == 0) begin
                    chk("spurious_done", {62'd0, d[1], d[0]}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("done_port", {62'd0, d[1], d[0]}, e.port == 1 ? 64'd2 : 64'd1);
                    chk("req0_rdata", 64'(rd[0]), 64'(e.rd0));
                    chk("req1_rdata", 64'(rd[1]), 64'(e.rd1));
                end
            end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
                chk("missing_done", 64'(0), 64'(1));
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int p, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] w);
        s[p] = 1'b1; rw[p] = r; addr[p] = a; wd[p] = w;
    endtask

    task automatic rand_req(input int p);
        raise(p, 1'($urandom), AW'($urandom), $urandom);
    endtask

    // Wait for port p to complete, then drop its strobe in the following IDLE cycle
    task automatic wait_done(input int p);
        int n = 0;
        while (done_cnt[p] == seen[p] && n < 60) begin
            tick();
            n++;
        end
        chk($sformatf("done_seen_port%0d", p), 64'(done_cnt[p] != seen[p]), 64'(1));
        seen[p] = done_cnt[p];
        s[p]    = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_mstrobe"}, 64'(m_strobe), 64'(0));
        chk({tag, "_done0"}, 64'(d[0]), 64'(0));
        chk({tag, "_done1"}, 64'(d[1]), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_mrw"}, 64'(m_rw), 64'(0));
        chk({tag, "_maddr"}, 64'(m_addr), 64'(0));
        chk({tag, "_mwdata"}, 64'(m_wdata), 64'(0));
        chk({tag, "_rdata0"}, 64'(rd[0]), 64'(0));
        chk({tag, "_rdata1"}, 64'(rd[1]), 64'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            s[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        reset_vals("after_reset");
        mon_en = 1'b1;

        // Single read: strobe one cycle after sampling, done WAIT+2 cycles after
        mem[0] = 32'hDEADBEEF;
        tick();
        raise(0, 1'b0, 16'h0010, 32'h0);
        wait_done(0);
        chk("read_rdata", 64'(rd[0]), 64'h0000_0000_DEAD_BEEF);

        // Single write on port 1 leaves its read register untouched
        raise(1, 1'b1, 16'h0020, 32'h1234_5678);
        wait_done(1);
        chk("write_rdata1_unchanged", 64'(rd[1]), 64'(0));

        // Port 1 arrives mid-access; it must wait for the IDLE after port 0 completes
        tick();
        raise(0, 1'b0, 16'h0031, 32'h0);
        repeat (3) tick();
        raise(1, 1'b0, 16'h0042, 32'h0);
        wait_done(0);
        wait_done(1);

        // Both ports hold requests through six completions
        tick();
        raise(0, 1'b0, 16'h0005, 32'h0);
        raise(1, 1'b1, 16'h0006, 32'hA5A5_0001);
        n = 0;
        while ((done_cnt[0] + done_cnt[1]) - (seen[0] + seen[1]) < 6 && n < 200) begin
            tick();
            n++;
        end
        chk("contention_completions", 64'((done_cnt[0] + done_cnt[1]) - (seen[0] + seen[1])),
            64'(6));
        s[0] = 1'b0; s[1] = 1'b0;
        seen[0] = done_cnt[0]; seen[1] = done_cnt[1];
        repeat (3) tick();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (s[p] && done_cnt[p] != seen[p]) begin
                    seen[p] = done_cnt[p];
                    if ($urandom_range(1, 0) == 1) rand_req(p);
                    else s[p] = 1'b0;
                end else if (!s[p]) begin
                    if ($urandom_range(2, 0) == 0) rand_req(p);
                end else if ($urandom_range(7, 0) == 0) begin
                    rand_req(p);
                end
            end
        end
        n = 0;
        while ((s[0] || s[1]) && n < 200) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (s[p] && done_cnt[p] != seen[p]) begin
                    seen[p] = done_cnt[p];
                    s[p]    = 1'b0;
                end
            end
            n++;
        end
        chk("drain_strobes_low", 64'(s[0] || s[1]), 64'(0));
        repeat (4) tick();

        // Reset on the second wait cycle abandons the access
        raise(0, 1'b0, 16'h0003, 32'h0);
        n = 0;
        while (!m_strobe && n < 20) begin
            tick();
            n++;
        end
        chk("abort_strobe_seen", 64'(m_strobe), 64'(1));
        tick();
        tick();
        reset = 1'b1;
        s[0]  = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        reset_vals("abort");
        repeat (10) tick();
        chk("abort_no_done", 64'(done_cnt[0] - seen[0]), 64'(0));
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
